// File: rtl/spi_pkg.sv
// Shared types for the parametrised SPI master: FSM state encoding and the
// latched clock-mode pair.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEAD  = 2'd1,
        XFER  = 2'd2,
        TRAIL = 2'd3
    } spi_state_e;

    typedef struct packed {
        logic cpol;
        logic cpha;
    } spi_mode_t;

    // Width of the down-counter that walks the 2*data_w sck half-periods.
    function automatic int edge_cnt_w(input int data_w);
        return $clog2(2 * data_w);
    endfunction

endpackage

// File: rtl/spi_baud_gen.sv
// Half-period timer: down-counter reloaded from div, one-cycle tick on
// terminal count, so ticks arrive every div+1 cycles while enabled.
module spi_baud_gen #(
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= div;
        end else if (en) begin
            if (cnt == '0) begin
                cnt <= div;
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

    assign tick = en && (cnt == '0);

endmodule

// File: rtl/spi_master_param.sv
// Parametrised SPI master: one-entry transmit holding buffer, CPOL/CPHA modes,
// LSB-first option, programmable half-period, one-hot-low slave selects.
//
// state | meaning
// IDLE  | ss_n high, sck = cpol; starts a frame when the holding buffer is full
// LEAD  | ss_n low, one half-period of setup before the first sck edge
// XFER  | 2*DATA_W half-periods, sck toggling at each boundary
// TRAIL | sck back at cpol, ss_n held low one half-period
module spi_master_param
    import spi_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int NUM_SS = 1,
    parameter int DIV_W  = 8,
    parameter int SEL_W  = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              spe,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsbfe,
    input  logic [DIV_W-1:0]  baud_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic [SEL_W-1:0]  tx_sel,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              spif,
    output logic              busy,
    output logic              sck,
    output logic              mosi,
    input  logic              miso,
    output logic [NUM_SS-1:0] ss_n
);

    localparam int CNT_W = edge_cnt_w(DATA_W);
    localparam logic [CNT_W-1:0] LAST_EDGE = CNT_W'(2 * DATA_W - 1);

    spi_state_e        state, state_nxt;

    logic              buf_full;
    logic [DATA_W-1:0] buf_data;
    logic [SEL_W-1:0]  buf_sel;

    spi_mode_t         mode_q;
    logic              lsbfe_q;
    logic [DIV_W-1:0]  div_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] tx_sr;
    logic [DATA_W-1:0] rx_sr;
    logic [DATA_W-1:0] rx_q;
    logic [CNT_W-1:0]  rem;
    logic              sck_q;
    logic              mosi_q;
    logic              spif_q;

    logic              tick;
    logic [DIV_W-1:0]  baud_ld;
    logic              wr;
    logic              load;
    logic              sck_edge;
    logic              lead_edge;
    logic              shift_ev;
    logic              sample_ev;
    logic              frame_done;

    function automatic logic head_bit(input logic [DATA_W-1:0] d, input logic lsb_first);
        return lsb_first ? d[0] : d[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] d,
                                                    input logic lsb_first);
        return lsb_first ? {1'b0, d[DATA_W-1:1]} : {d[DATA_W-2:0], 1'b0};
    endfunction

    // While idle the timer is preloaded from the live divisor so LEAD starts
    // with a full half-period; during the frame it reloads from the latched copy.
    assign baud_ld = (state == IDLE) ? baud_div : div_q;

    spi_baud_gen #(.DIV_W(DIV_W)) u_baud (
        .clk  (clk),
        .rst  (rst),
        .en   (state != IDLE),
        .load (state == IDLE),
        .div  (baud_ld),
        .tick (tick)
    );

    assign wr         = tx_valid && !buf_full && spe;
    assign load       = (state == IDLE) && spe && buf_full;
    assign frame_done = spe && (state == TRAIL) && tick;

    // rem holds the number of sck edges still to come after the current one;
    // with 2*DATA_W-1 odd, a leading edge is one that leaves rem odd.
    assign sck_edge  = spe && tick && ((state == LEAD) || ((state == XFER) && (rem != '0)));
    assign lead_edge = (state == LEAD) || !rem[0];
    assign shift_ev  = sck_edge && (lead_edge == mode_q.cpha);
    assign sample_ev = sck_edge && (lead_edge != mode_q.cpha);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (buf_full)              state_nxt = LEAD;
            LEAD:    if (tick)                  state_nxt = XFER;
            XFER:    if (tick && rem == '0)     state_nxt = TRAIL;
            TRAIL:   if (tick)                  state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
        if (!spe) begin
            state_nxt = IDLE;
        end
    end

    always_comb begin
        ss_n     = '1;
        busy     = (state != IDLE) || spif_q;
        tx_ready = !buf_full;
        for (int i = 0; i < NUM_SS; i++) begin
            if ((state != IDLE) && (sel_q == SEL_W'(i))) begin
                ss_n[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_full <= 1'b0;
            buf_data <= '0;
            buf_sel  <= '0;
        end else if (!spe || load) begin
            buf_full <= 1'b0;
        end else if (wr) begin
            buf_full <= 1'b1;
            buf_data <= tx_data;
            buf_sel  <= tx_sel;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q  <= '0;
            lsbfe_q <= 1'b0;
            div_q   <= '0;
            sel_q   <= '0;
            tx_sr   <= '0;
            mosi_q  <= 1'b0;
        end else if (load) begin
            mode_q  <= '{cpol: cpol, cpha: cpha};
            lsbfe_q <= lsbfe;
            div_q   <= baud_div;
            sel_q   <= buf_sel;
            // CPHA=0 needs the first bit on the line before the first sck edge.
            if (!cpha) begin
                mosi_q <= head_bit(buf_data, lsbfe);
                tx_sr  <= shift_out(buf_data, lsbfe);
            end else begin
                tx_sr  <= buf_data;
            end
        end else if (shift_ev) begin
            mosi_q <= head_bit(tx_sr, lsbfe_q);
            tx_sr  <= shift_out(tx_sr, lsbfe_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_sr <= '0;
        end else if (sample_ev) begin
            rx_sr <= lsbfe_q ? {miso, rx_sr[DATA_W-1:1]} : {rx_sr[DATA_W-2:0], miso};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rem <= '0;
        end else if ((state == LEAD) && tick) begin
            rem <= LAST_EDGE;
        end else if ((state == XFER) && tick && (rem != '0)) begin
            rem <= rem - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sck_q <= 1'b0;
        end else if (!spe || (state == IDLE)) begin
            sck_q <= cpol;
        end else if (state == TRAIL) begin
            sck_q <= mode_q.cpol;
        end else if (sck_edge) begin
            sck_q <= !sck_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            spif_q <= 1'b0;
            rx_q   <= '0;
        end else begin
            spif_q <= frame_done;
            if (frame_done) begin
                rx_q <= rx_sr;
            end
        end
    end

    assign sck     = sck_q;
    assign mosi    = mosi_q;
    assign spif    = spif_q;
    assign rx_data = rx_q;

endmodule

// File: tb/tb_spi_master_param.sv
// Bench for spi_master_param: an 8-bit/3-slave instance exercised by directed
// and random frames against a behavioural SPI slave, plus a 16-bit/4-slave
// instance for back-to-back frames.
module tb_spi_master_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_mis = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: DATA_W=8, NUM_SS=3 ----------------
    logic       spe_a = 1'b1, cpol_a = 1'b0, cpha_a = 1'b0, lsbfe_a = 1'b0;
    logic [7:0] div_a = '0, txd_a = '0;
    logic [1:0] sel_a = '0;
    logic       txv_a = 1'b0;
    logic       ready_a, spif_a, busy_a, sck_a, mosi_a, miso_a;
    logic [7:0] rxd_a;
    logic [2:0] ss_a;

    spi_master_param #(.DATA_W(8), .NUM_SS(3), .DIV_W(8)) dut_a (
        .clk(clk), .rst(rst), .spe(spe_a), .cpol(cpol_a), .cpha(cpha_a),
        .lsbfe(lsbfe_a), .baud_div(div_a), .tx_data(txd_a), .tx_sel(sel_a),
        .tx_valid(txv_a), .tx_ready(ready_a), .rx_data(rxd_a), .spif(spif_a),
        .busy(busy_a), .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .ss_n(ss_a)
    );

    // ---------------- instance B: DATA_W=16, NUM_SS=4 ----------------
    logic        spe_b = 1'b1, cpol_b = 1'b0, cpha_b = 1'b1, lsbfe_b = 1'b0;
    logic [7:0]  div_b = 8'd1;
    logic [15:0] txd_b = '0;
    logic [1:0]  sel_b = '0;
    logic        txv_b = 1'b0;
    logic        ready_b, spif_b, busy_b, sck_b, mosi_b;
    logic [15:0] rxd_b;
    logic [3:0]  ss_b;

    spi_master_param #(.DATA_W(16), .NUM_SS(4), .DIV_W(8)) dut_b (
        .clk(clk), .rst(rst), .spe(spe_b), .cpol(cpol_b), .cpha(cpha_b),
        .lsbfe(lsbfe_b), .baud_div(div_b), .tx_data(txd_b), .tx_sel(sel_b),
        .tx_valid(txv_b), .tx_ready(ready_b), .rx_data(rxd_b), .spif(spif_b),
        .busy(busy_b), .sck(sck_b), .mosi(mosi_b), .miso(mosi_b), .ss_n(ss_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic bit_at(input logic [15:0] w, input int k, input bit lsb, input int dw);
        return lsb ? w[k] : w[dw-1-k];
    endfunction

    // ---------------- behavioural slave + monitor for A ----------------
    bit         m_cpol, m_cpha, m_lsb, loop_a;
    logic [7:0] slv_resp, slv_rx;
    int         slv_rx_idx, slv_tx_idx;
    logic       slv_miso = 1'b0;
    logic       prev_sck_a = 1'b0;
    int         ss_low_a, busy_cnt_a, rise_a, spif_cnt_a;
    int         first_low_a, last_low_a, spif_cyc_a;
    bit         seen_low_a;

    assign miso_a = loop_a ? mosi_a : slv_miso;

    always @(negedge clk) begin
        prev_sck_a <= sck_a;
        if (rst) begin
            if (ss_a != 3'b111) begin
                ss_low_a    <= ss_low_a + 1;
                last_low_a  <= cyc;
                seen_low_a  <= 1'b1;
                if (!seen_low_a) first_low_a <= cyc;
            end
            if (busy_a) busy_cnt_a <= busy_cnt_a + 1;
            if (spif_a) begin
                spif_cnt_a <= spif_cnt_a + 1;
                spif_cyc_a <= cyc;
            end
            if (sck_a != prev_sck_a) begin
                if (sck_a) rise_a <= rise_a + 1;
                // Slave samples on the same edge type as the master; it
                // shifts on the other one.
                if ((sck_a != m_cpol) != m_cpha) begin
                    if (slv_rx_idx < 8) begin
                        if (m_lsb) slv_rx[slv_rx_idx] <= mosi_a;
                        else       slv_rx[7-slv_rx_idx] <= mosi_a;
                        slv_rx_idx <= slv_rx_idx + 1;
                    end
                end else if (slv_tx_idx < 8) begin
                    slv_miso   <= bit_at({8'h00, slv_resp}, slv_tx_idx, m_lsb, 8);
                    slv_tx_idx <= slv_tx_idx + 1;
                end
            end
        end
    end

    task automatic clr_mon_a();
        ss_low_a = 0; busy_cnt_a = 0; rise_a = 0; spif_cnt_a = 0;
        first_low_a = 0; last_low_a = 0; spif_cyc_a = 0; seen_low_a = 1'b0;
    endtask

    task automatic frame_a(input logic [7:0] data, input logic [7:0] resp, input bit pol,
                           input bit pha, input bit lsb, input logic [7:0] div,
                           input bit loop, input logic [1:0] sel, input string tag);
        int budget;
        int wr_cyc;
        int h;
        @(posedge clk); #1;
        m_cpol = pol; m_cpha = pha; m_lsb = lsb; loop_a = loop;
        cpol_a = pol; cpha_a = pha; lsbfe_a = lsb; div_a = div;
        repeat (2) @(posedge clk);
        #1;
        slv_resp = resp; slv_rx = '0; slv_rx_idx = 0;
        slv_tx_idx = pha ? 0 : 1;
        slv_miso = pha ? 1'b0 : bit_at({8'h00, resp}, 0, lsb, 8);
        clr_mon_a();
        @(negedge clk);
        chk({tag, "_ready_before"}, ready_a, 1'b1);
        txd_a = data; sel_a = sel; txv_a = 1'b1; wr_cyc = cyc;
        @(negedge clk);
        txv_a = 1'b0;
        h = int'(div) + 1;
        budget = h * 18 + 40;
        while (spif_cnt_a == 0 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        chk({tag, "_ss_low"}, ss_low_a, (sel < 2'd3) ? h * 18 : 0);
        chk({tag, "_busy"}, busy_cnt_a, h * 18 + 1);
        chk({tag, "_sck_rises"}, rise_a, 8);
        chk({tag, "_spif"}, spif_cnt_a, 1);
        chk({tag, "_rx_data"}, rxd_a, loop ? data : resp);
        chk({tag, "_slave_rx"}, slv_rx, data);
        chk({tag, "_sck_idle"}, sck_a, pol);
        if (sel < 2'd3) begin
            chk({tag, "_ss_latency"}, first_low_a - wr_cyc, 2);
            chk({tag, "_spif_at_ss_rise"}, spif_cyc_a - last_low_a, 1);
        end
    endtask

    // ---------------- monitor for B ----------------
    logic [3:0]  prev_ss_b = 4'hF;
    logic        prev_rdy_b = 1'b1;
    int          falls_b[4];
    int          fall_q[$], rise_q[$], rdy_q[$];
    logic [15:0] rxb_q[$];
    int          spif_cnt_b;

    always @(negedge clk) begin
        prev_ss_b  <= ss_b;
        prev_rdy_b <= ready_b;
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                if (prev_ss_b[i] && !ss_b[i]) falls_b[i] <= falls_b[i] + 1;
            end
            if (prev_ss_b[2] && !ss_b[2]) fall_q.push_back(cyc);
            if (!prev_ss_b[2] && ss_b[2]) rise_q.push_back(cyc);
            if (!prev_rdy_b && ready_b)   rdy_q.push_back(cyc);
            if (spif_b) begin
                spif_cnt_b <= spif_cnt_b + 1;
                rxb_q.push_back(rxd_b);
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] rx_before;
        int budget;
        loop_a = 1'b0; m_cpol = 1'b0; m_cpha = 1'b0; m_lsb = 1'b0;
        slv_resp = '0; slv_rx = '0; slv_rx_idx = 0; slv_tx_idx = 0;
        clr_mon_a();
        spif_cnt_b = 0;
        foreach (falls_b[i]) falls_b[i] = 0;

        #12;
        chk("rst_ss_n", ss_a, 3'b111);
        chk("rst_sck", sck_a, 1'b0);
        chk("rst_mosi", mosi_a, 1'b0);
        chk("rst_rx_data", rxd_a, 8'h00);
        chk("rst_spif", spif_a, 1'b0);
        chk("rst_busy", busy_a, 1'b0);
        chk("rst_tx_ready", ready_a, 1'b1);
        chk("rst_ss_n_b", ss_b, 4'hF);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        frame_a(8'hA5, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 2'd0, "mode0_loop");
        frame_a(8'h81, 8'h3C, 1'b1, 1'b1, 1'b1, 8'd3, 1'b0, 2'd1, "mode3_lsb");

        // Asynchronous reset in the middle of a frame.
        frame_a(8'h0F, 8'h00, 1'b0, 1'b0, 1'b0, 8'd1, 1'b1, 2'd2, "pre_rst");
        @(negedge clk);
        txd_a = 8'hC3; sel_a = 2'd0; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        repeat (10) @(negedge clk);
        chk("mid_frame_busy", busy_a, 1'b1);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("async_rst_ss_n", ss_a, 3'b111);
        chk("async_rst_sck", sck_a, 1'b0);
        chk("async_rst_mosi", mosi_a, 1'b0);
        chk("async_rst_rx_data", rxd_a, 8'h00);
        chk("async_rst_spif", spif_a, 1'b0);
        chk("async_rst_busy", busy_a, 1'b0);
        chk("async_rst_tx_ready", ready_a, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        frame_a(8'h5A, 8'h00, 1'b0, 1'b0, 1'b0, 8'd0, 1'b1, 2'd0, "post_rst");

        // spe dropped mid-XFER with the holding buffer full.
        frame_a(8'h6E, 8'hD2, 1'b0, 1'b1, 1'b0, 8'd2, 1'b0, 2'd1, "pre_abort");
        @(negedge clk);
        txd_a = 8'h77; sel_a = 2'd0; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        budget = 10;
        while (!ready_a && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        txd_a = 8'h11; txv_a = 1'b1;
        @(negedge clk);
        txv_a = 1'b0;
        chk("abort_buf_full", ready_a, 1'b0);
        repeat (12) @(negedge clk);
        rx_before = rxd_a;
        spe_a = 1'b0;
        @(negedge clk);
        chk("abort_ss_n", ss_a, 3'b111);
        chk("abort_sck", sck_a, cpol_a);
        chk("abort_spif", spif_a, 1'b0);
        chk("abort_tx_ready", ready_a, 1'b1);
        chk("abort_rx_data", rxd_a, rx_before);
        @(posedge clk); #1;
        spe_a = 1'b1;
        clr_mon_a();
        repeat (40) @(negedge clk);
        chk("abort_flushed_ss", ss_low_a, 0);
        chk("abort_no_spif", spif_cnt_a, 0);

        frame_a(8'h96, 8'h4B, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 2'd2, "max_div");
        frame_a(8'hE7, 8'h18, 1'b1, 1'b0, 1'b1, 8'd1, 1'b0, 2'd3, "no_slave");

        for (int n = 0; n < 10; n++) begin
            frame_a(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                    8'($urandom_range(0, 4)), 1'($urandom), 2'($urandom), "rnd");
        end

        // Back-to-back 16-bit frames on slave 2.
        @(posedge clk); #1;
        spif_cnt_b = 0;
        foreach (falls_b[i]) falls_b[i] = 0;
        fall_q.delete(); rise_q.delete(); rdy_q.delete(); rxb_q.delete();
        @(negedge clk);
        txd_b = 16'h1234; sel_b = 2'd2; txv_b = 1'b1;
        @(negedge clk);
        txv_b = 1'b0;
        budget = 10;
        while (!ready_b && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        txd_b = 16'hBEEF; txv_b = 1'b1;
        @(negedge clk);
        txv_b = 1'b0;
        budget = 200;
        while (spif_cnt_b < 2 && budget > 0) begin
            @(negedge clk);
            budget--;
        end
        repeat (3) @(negedge clk);
        chk("b2b_spif_count", spif_cnt_b, 2);
        chk("b2b_ss0_quiet", falls_b[0], 0);
        chk("b2b_ss1_quiet", falls_b[1], 0);
        chk("b2b_ss3_quiet", falls_b[3], 0);
        chk("b2b_ss2_falls", falls_b[2], 2);
        chk("b2b_rx_count", rxb_q.size(), 2);
        if (rxb_q.size() == 2) begin
            chk("b2b_rx0", rxb_q[0], 16'h1234);
            chk("b2b_rx1", rxb_q[1], 16'hBEEF);
        end
        if (fall_q.size() == 2 && rise_q.size() >= 1) begin
            chk("b2b_ss_low_len", rise_q[0] - fall_q[0], 2 * 34);
            chk("b2b_gap", fall_q[1] - rise_q[0], 1);
        end
        chk("b2b_ready_rises", rdy_q.size(), 2);
        if (rdy_q.size() == 2 && fall_q.size() == 2) begin
            chk("b2b_ready_at_start0", rdy_q[0], fall_q[0]);
            chk("b2b_ready_at_start1", rdy_q[1], fall_q[1]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/spi_master_param.md
# spi_master_param

Parametrised SPI master for the SPI subsystem. It generalises the fixed 8-bit master: configurable frame width, configurable slave-select count, all four CPOL/CPHA modes, LSB-first option, a programmable baud divisor and a one-entry transmit holding buffer for back-to-back frames. It sits between the register/user interface (data, control and baud registers, plus the transfer-complete flag) and the external SCK/MOSI/MISO/SS pins.

## Interface
- DATA_W, 8, frame width in bits (≥2)
- NUM_SS, 1, number of active-low slave selects (≥1)
- DIV_W, 8, baud divisor width
- SEL_W, $clog2(NUM_SS) min 1, slave-select index width
- clk  in  1  system clock; everything is on the rising edge
- rst  in  1  reset, asynchronous, active-low
- spe  in  1  SPI enable; low aborts and holds idle
- cpol, cpha, lsbfe  in  1 each  mode bits, latched at frame start
- baud_div  in  DIV_W  half-period = baud_div+1 clk cycles, latched at frame start
- tx_data  in  DATA_W  frame to send
- tx_sel  in  SEL_W  target slave, captured with tx_data
- tx_valid  in  1  write request
- tx_ready  out  1  holding buffer empty (SPTEF equivalent)
- rx_data  out  DATA_W  last received frame
- spif  out  1  one-cycle frame-complete pulse
- busy  out  1  frame in progress
- sck, mosi  out  1 each
- miso  in  1
- ss_n  out  NUM_SS  one-hot-low slave selects

## Operation
- Reset values: ss_n all 1, sck 0, mosi 0, rx_data 0, spif 0, busy 0, tx_ready 1, state IDLE, holding buffer empty.
- Write accepted when tx_valid && tx_ready && spe; tx_data/tx_sel go to the holding buffer, and tx_ready drops the next cycle. tx_sel ≥ NUM_SS: the write is accepted and the frame is sent with no ss_n asserted.
- FSM: IDLE → LEAD → XFER → TRAIL → IDLE.
- IDLE: sck = cpol. With the buffer full, load the shift register, latch the mode and baud_div, empty the buffer (tx_ready=1) and go to LEAD.
- LEAD: ss_n[sel] low, h = baud_div+1 cycles. For CPHA=0, the first bit is on mosi on entry to LEAD.
- XFER: 2·DATA_W half-periods of h cycles. sck toggles at each half-period boundary.
  - CPHA=0: sample miso on leading edges, shift mosi on trailing edges.
  - CPHA=1: shift on leading edges, sample on trailing edges.
- Bit order: lsbfe=1 shifts LSB first, else MSB first. The received bits are assembled in the same order.
- TRAIL: sck = cpol and ss_n held low for h cycles. At exit: ss_n all high, rx_data updated, spif=1 for one cycle, state IDLE.
- Back-to-back: if the buffer is full at TRAIL exit, spend exactly one cycle in IDLE (ss_n high), then start the next LEAD.
- spe low in any state: next cycle IDLE, ss_n high, sck=cpol, buffer flushed, no spif, rx_data unchanged.
- A write during the spif cycle is legal.
- Asynchronous reset mid-frame forces the reset values immediately.

## Timing
- Write accepted at cycle 0 → ss_n low from cycle 2 (buffer at 1, IDLE decision at 1).
- ss_n low exactly h·(2·DATA_W+2) cycles; spif is asserted in the cycle ss_n returns high.
- Back-to-back gap: ss_n high exactly 1 cycle.
- busy = 1 from LEAD entry through the spif cycle.
- The miso sample is taken on the clk edge that produces the corresponding sck edge.

## Structure
- Package spi_pkg: state enum (IDLE, LEAD, XFER, TRAIL) and a mode type {cpol, cpha}.
- Sub-module spi_baud_gen: DIV_W counter with a load/clear input. It emits a one-cycle tick every baud_div+1 cycles while enabled. The FSM counts ticks for LEAD, XFER and TRAIL.
- The rest (FSM, shift register, holding buffer, ss decode) stays in the top; about 200–300 lines.

## Test plan
- Mode 0, DATA_W=8, baud_div=0, miso looped to mosi, write 0xA5 → rx_data 0xA5; ss_n low 18 cycles; one spif; sck has 8 rising edges.
- Mode 3, lsbfe=1, baud_div=3, miso driven by a slave model returning 0x3C, write 0x81 → mosi bit sequence 1,0,0,0,0,0,0,1; rx_data 0x3C; ss_n low 72 cycles; sck idles high.
- DATA_W=16, NUM_SS=4, tx_sel=2, back-to-back writes 0x1234 then 0xBEEF → only ss_n[2] toggles; two spif pulses; 1-cycle ss_n-high gap; tx_ready returns 1 right after each frame start.
- spe dropped mid-XFER with the buffer full → next cycle ss_n all high, sck=cpol, no spif, tx_ready=1, rx_data unchanged.
- rst asserted mid-frame (asynchronous, between clk edges) → outputs at reset values before the next clk edge; after release, a 0x5A loopback completes normally.
- baud_div = max (255) → half-period 256 cycles; ss_n low 256·18 cycles for DATA_W=8; no divisor wrap error.
